game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 28 ++
 rtl/game_ctrl_bcd2_counter.sv | 56 +++++
 rtl/game_ctrl.sv | 129 ++++++++++++
 tb/tb_game_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the whack-a-target game controller.
// Holds FSM encoding, BCD digit width and the default position count.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_PLAY = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam int DIGIT_W     = 4;
  localparam int NUM_POS_DEF = 9;

  // Reduce a 4-bit draw into 0..n-1 by repeated subtraction.
  function automatic logic [3:0] pos_mod(
    input logic [3:0]  p,
    input int unsigned n
  );
    logic [4:0] v;
    v = {1'b0, p};
    for (int i = 0; i < 8; i++) begin
      if (v >= 5'(n)) v = v - 5'(n);
    end
    return v[3:0];
  endfunction

endpackage

// File: rtl/game_ctrl_bcd2_counter.sv
// Two-digit BCD counter with load, increment and decrement.
// Saturates at 00 when counting down and at 99 when counting up.
module bcd2_counter
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] ld_tens_i,
  input  logic [DIGIT_W-1:0] ld_ones_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [DIGIT_W-1:0] tens_o,
  output logic [DIGIT_W-1:0] ones_o
);

  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (load_i) begin
      tens_d = ld_tens_i;
      ones_d = ld_ones_i;
    end else if (inc_i) begin
      if (ones_q != 4'd9) begin
        ones_d = ones_q + 4'd1;
      end else if (tens_q != 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end
    end else if (dec_i) begin
      if (ones_q != 4'd0) begin
        ones_d = ones_q - 4'd1;
      end else if (tens_q != 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens_o = tens_q;
  assign ones_o = ones_q;

endmodule

// File: rtl/game_ctrl.sv
// Target-shooting game controller: arms targets, scores hits,
// counts down the game clock and reports game over.
module game_ctrl
  import game_pkg::*;
#(
  parameter int GAME_SECONDS = 30,
  parameter int TARGET_HOLD  = 2,
  parameter int NUM_POS      = NUM_POS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               tick_1hz,
  input  logic [3:0]         position,
  input  logic [NUM_POS-1:0] key_pulse,
  output logic               in_game,
  output logic [3:0]         target,
  output logic               target_valid,
  output logic [DIGIT_W-1:0] time_tens,
  output logic [DIGIT_W-1:0] time_ones,
  output logic [DIGIT_W-1:0] score_tens,
  output logic [DIGIT_W-1:0] score_ones,
  output logic               game_over
);

  localparam logic [3:0] T_TENS = 4'(GAME_SECONDS / 10);
  localparam logic [3:0] T_ONES = 4'(GAME_SECONDS % 10);
  localparam logic [3:0] HOLD   = 4'(TARGET_HOLD);

  state_e     state_q, state_d;
  logic [3:0] target_q, target_d;
  logic [3:0] hold_q, hold_d;
  logic       in_game_q, in_game_d;
  logic       tv_q, tv_d;
  logic       go_q, go_d;

  logic [15:0] keys;
  logic        arm, play, launch;
  logic        hit, tick_p, last_tick, miss;

  always_comb begin
    keys      = 16'(key_pulse);
    arm       = (state_q == ST_ARM);
    play      = (state_q == ST_PLAY);
    launch    = ((state_q == ST_IDLE) || (state_q == ST_OVER)) && start;
    hit       = play && !abort && keys[target_q];
    tick_p    = play && !abort && tick_1hz;
    last_tick = tick_p && (time_tens == 4'd0) && (time_ones == 4'd1);
    miss      = tick_p && (hold_q == 4'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      target_q  <= '0;
      hold_q    <= '0;
      in_game_q <= 1'b0;
      tv_q      <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      hold_q    <= hold_d;
      in_game_q <= in_game_d;
      tv_q      <= tv_d;
      go_q      <= go_d;
    end
  end

  // Abort beats game end, which beats re-arming after hit or miss.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_OVER: if (start) state_d = ST_ARM;
      ST_ARM:  state_d = abort ? ST_IDLE : ST_PLAY;
      ST_PLAY: begin
        if (abort)              state_d = ST_IDLE;
        else if (last_tick)     state_d = ST_OVER;
        else if (hit || miss)   state_d = ST_ARM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    target_d  = target_q;
    hold_d    = hold_q;
    if (arm && !abort) begin
      target_d = pos_mod(position, NUM_POS);
      hold_d   = HOLD;
    end else if (tick_p) begin
      hold_d   = hold_q - 4'd1;
    end
    in_game_d = (state_d == ST_ARM) || (state_d == ST_PLAY);
    tv_d      = (state_d == ST_PLAY);
    go_d      = (state_d == ST_OVER);
  end

  bcd2_counter u_time (
    .clk       (clk),
    .rst       (rst),
    .load_i    (launch),
    .ld_tens_i (T_TENS),
    .ld_ones_i (T_ONES),
    .inc_i     (1'b0),
    .dec_i     (tick_p),
    .tens_o    (time_tens),
    .ones_o    (time_ones)
  );

  bcd2_counter u_score (
    .clk       (clk),
    .rst       (rst),
    .load_i    (launch),
    .ld_tens_i (4'd0),
    .ld_ones_i (4'd0),
    .inc_i     (hit),
    .dec_i     (1'b0),
    .tens_o    (score_tens),
    .ones_o    (score_ones)
  );

  assign in_game      = in_game_q;
  assign target       = target_q;
  assign target_valid = tv_q;
  assign game_over    = go_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: directed cycles push expected
// output snapshots; a monitor pops and compares them.
module tb_game_ctrl;

  localparam int NP = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          tick_1hz = 1'b0;
  logic [3:0]    position = 4'd0;
  logic [NP-1:0] key_pulse = '0;

  logic       in_game, target_valid, game_over;
  logic [3:0] target;
  logic [3:0] time_tens, time_ones, score_tens, score_ones;

  game_ctrl #(
    .GAME_SECONDS (3),
    .TARGET_HOLD  (2),
    .NUM_POS      (NP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .tick_1hz     (tick_1hz),
    .position     (position),
    .key_pulse    (key_pulse),
    .in_game      (in_game),
    .target       (target),
    .target_valid (target_valid),
    .time_tens    (time_tens),
    .time_ones    (time_ones),
    .score_tens   (score_tens),
    .score_ones   (score_ones),
    .game_over    (game_over)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic       ig;
    logic [3:0] tgt;
    logic       tv;
    logic [3:0] tt;
    logic [3:0] to;
    logic [3:0] st;
    logic [3:0] so;
    logic       go;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  event  chk_ev;

  initial begin
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        obs_t  e;
        obs_t  g;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        g = {in_game, target, target_valid, time_tens,
             time_ones, score_tens, score_ones, game_over};
        checks++;
        if (g !== e) begin
          errors++;
          $display(
            "FAIL %s got ig=%0d tgt=%0d tv=%0d t=%0d%0d s=%0d%0d go=%0d exp ig=%0d tgt=%0d tv=%0d t=%0d%0d s=%0d%0d go=%0d",
            n, g.ig, g.tgt, g.tv, g.tt, g.to, g.st, g.so, g.go,
            e.ig, e.tgt, e.tv, e.tt, e.to, e.st, e.so, e.go);
        end
      end
    end
  end

  task automatic push(
    input logic ig, input logic [3:0] tgt, input logic tv,
    input logic [3:0] tt, input logic [3:0] to,
    input logic [3:0] st, input logic [3:0] so,
    input logic go, input string nm
  );
    exp_q.push_back({ig, tgt, tv, tt, to, st, so, go});
    name_q.push_back(nm);
  endtask

  task automatic cyc(
    input logic s, input logic a, input logic t,
    input logic [NP-1:0] k,
    input logic ig, input logic [3:0] tgt, input logic tv,
    input logic [3:0] tt, input logic [3:0] to,
    input logic [3:0] st, input logic [3:0] so,
    input logic go, input string nm
  );
    start     = s;
    abort     = a;
    tick_1hz  = t;
    key_pulse = k;
    @(posedge clk);
    #1;
    push(ig, tgt, tv, tt, to, st, so, go, nm);
    start     = 1'b0;
    abort     = 1'b0;
    tick_1hz  = 1'b0;
    key_pulse = '0;
  endtask

  localparam logic [NP-1:0] K0 = '0;
  localparam logic [NP-1:0] K2 = 9'h004;

  initial begin
    #5;
    push(0, 0, 0, 0, 0, 0, 0, 0, "reset");
    -> chk_ev;
    @(negedge clk);
    #5 rst = 1'b1;

    // game runs out with no keys; miss every two ticks
    position = 4'd13;
    cyc(1, 0, 0, K0, 1, 0, 0, 0, 3, 0, 0, 0, "s1_start");
    cyc(0, 0, 0, K0, 1, 4, 1, 0, 3, 0, 0, 0, "s1_arm");
    cyc(0, 0, 1, K0, 1, 4, 1, 0, 2, 0, 0, 0, "s1_tick1");
    position = 4'd5;
    cyc(0, 0, 1, K0, 1, 4, 0, 0, 1, 0, 0, 0, "s1_miss");
    cyc(1, 0, 1, '1, 1, 5, 1, 0, 1, 0, 0, 0, "s1_arm_ignores");
    cyc(0, 0, 1, K0, 0, 5, 0, 0, 0, 0, 0, 1, "s1_over");
    cyc(0, 0, 0, K0, 0, 5, 0, 0, 0, 0, 0, 1, "s1_over_hold");

    // target reduction and key selectivity
    position = 4'd13;
    cyc(1, 0, 0, K0, 1, 5, 0, 0, 3, 0, 0, 0, "s2_start");
    cyc(0, 0, 0, K0, 1, 4, 1, 0, 3, 0, 0, 0, "s2_target4");
    cyc(0, 0, 0, 9'h008, 1, 4, 1, 0, 3, 0, 0, 0, "s2_wrong_key");
    cyc(0, 0, 0, 9'h018, 1, 4, 0, 0, 3, 0, 1, 0, "s2_hit");
    position = 4'd2;
    cyc(0, 0, 0, K0, 1, 2, 1, 0, 3, 0, 1, 0, "s2_arm2");
    cyc(1, 0, 0, K0, 1, 2, 1, 0, 3, 0, 1, 0, "s2_start_ign");

    // hit coinciding with a miss, then with the final tick
    cyc(0, 0, 1, K0, 1, 2, 1, 0, 2, 0, 1, 0, "s4_tick");
    cyc(0, 0, 1, K2, 1, 2, 0, 0, 1, 0, 2, 0, "s4_hit_miss");
    cyc(0, 0, 0, K0, 1, 2, 1, 0, 1, 0, 2, 0, "s4_arm");
    cyc(0, 0, 1, K2, 0, 2, 0, 0, 0, 0, 3, 1, "s4_hit_final");

    // score carry and saturation
    cyc(1, 0, 0, K0, 1, 2, 0, 0, 3, 0, 0, 0, "s3_start");
    cyc(0, 0, 0, K0, 1, 2, 1, 0, 3, 0, 0, 0, "s3_arm");
    for (int n = 1; n <= 99; n++) begin
      cyc(0, 0, 0, K2, 1, 2, 0, 0, 3,
          4'(n / 10), 4'(n % 10), 0, $sformatf("s3_hit%0d", n));
      cyc(0, 0, 0, K0, 1, 2, 1, 0, 3,
          4'(n / 10), 4'(n % 10), 0, $sformatf("s3_rearm%0d", n));
    end
    cyc(0, 0, 0, K2, 1, 2, 0, 0, 3, 9, 9, 0, "s3_sat");
    cyc(0, 0, 0, K0, 1, 2, 1, 0, 3, 9, 9, 0, "s3_rearm_sat");

    // abort in PLAY and ARM, then restart
    position = 4'd7;
    cyc(0, 1, 1, K2, 0, 2, 0, 0, 3, 9, 9, 0, "s5_abort");
    cyc(0, 0, 0, K0, 0, 2, 0, 0, 3, 9, 9, 0, "s5_idle");
    cyc(1, 0, 0, K0, 1, 2, 0, 0, 3, 0, 0, 0, "s5_restart");
    cyc(0, 1, 0, K0, 0, 2, 0, 0, 3, 0, 0, 0, "s5_abort_arm");
    cyc(1, 0, 0, K0, 1, 2, 0, 0, 3, 0, 0, 0, "s5_start2");
    cyc(0, 0, 0, K0, 1, 7, 1, 0, 3, 0, 0, 0, "s5_play7");
    cyc(0, 0, 1, K0, 1, 7, 1, 0, 2, 0, 0, 0, "s6_tick");

    // asynchronous reset mid-PLAY
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    push(0, 0, 0, 0, 0, 0, 0, 0, "s6_async_rst");
    -> chk_ev;
    @(posedge clk);
    #1;
    push(0, 0, 0, 0, 0, 0, 0, 0, "s6_rst_held");
    @(negedge clk);
    #2 rst = 1'b1;
    cyc(0, 0, 1, K0, 0, 0, 0, 0, 0, 0, 0, 0, "s6_no_resume");
    cyc(1, 0, 0, K0, 1, 0, 0, 0, 3, 0, 0, 0, "s6_restart");

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
